dac_update_sched: RTL and testbench
===================================

DAC_UPDATE_SCHED -- requirements
Module: dac_update_sched

Interface
REQ-001 Parameter REFRESH_CYCLES, default 49152, SHALL set the periodic refresh interval in clkin cycles (1 ms at 49.152 MHz).
REQ-002 Parameter BUSY_TIMEOUT, default 16, SHALL set the maximum number of cycles from dac_trig to dac_busy=1.
REQ-003 Ports SHALL be as follows; one clock (clkin); reset is asynchronous and active-low (reset):
- clkin  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  host setpoint write strobe.
- wr_chan  in  2  channel for the write.
- wr_data  in  16  setpoint code for the write.
- safe  in  1  forces all channels to mid-scale.
- err_clr  in  1  clears err.
- dac_addr  in  4  word index from the DAC serial driver.
- dac_busy  in  1  DAC serial driver busy.
- dac_trig  out  1  one-cycle frame start to the driver.
- dac_word  out  32  command word for dac_addr.
- pending  out  1  OR of the dirty bits.
- frame_cnt  out  16  count of completed frames.
- err  out  1  sticky busy-timeout flag.

Function
REQ-004 Block SHALL hold 4 shadow setpoints (16 b), 4 dirty bits, a 4-entry frame buffer and a 4-state FSM: IDLE, TRIG, WAIT_BUSY, WAIT_DONE.
REQ-005 A cycle with wr_en=1 SHALL write wr_data to shadow[wr_chan] and set dirty[wr_chan] in any FSM state.
REQ-006 In IDLE with dac_busy=0 and a launch request (any dirty, refresh_due, or an edge of safe), the FSM SHALL do all of the following in that cycle, then go to TRIG:
- copy shadow into the frame buffer, or DAC_MIDSCALE into every entry when safe=1;
- clear dirty.
REQ-007 If wr_en coincides with a launch, the write SHALL take precedence: the written channel's dirty bit stays set and its new value goes out in the next frame.
REQ-008 dac_trig SHALL be 1 only in TRIG, for exactly one cycle, in the cycle after the launch decision (latency 1).
REQ-009 From TRIG the FSM SHALL go to WAIT_BUSY.
REQ-010 In WAIT_BUSY the FSM SHALL go to WAIT_DONE when dac_busy=1.
REQ-011 If dac_busy is not seen within BUSY_TIMEOUT cycles of TRIG, the FSM SHALL set err and return to IDLE without incrementing frame_cnt.
REQ-012 In WAIT_DONE, dac_busy=0 SHALL increment frame_cnt (wrapping 16'hFFFF to 0) and return the FSM to IDLE.
REQ-013 dac_word SHALL be combinational:
- dac_addr<4: {8'h00, DAC_CMD_WRUPD, 4'h0, framebuf[dac_addr[1:0]]};
- dac_addr>=4: 32'h0.
REQ-014 The frame buffer SHALL be unchanged outside a launch cycle, so writes made mid-frame never tear a frame.
REQ-015 Multiple writes to one channel before a launch SHALL produce one frame carrying the last value.
REQ-016 Both rising and falling edges of safe SHALL set all dirty bits; while safe=1, shadow writes are still accepted.
REQ-017 err SHALL be sticky until err_clr=1; if err_clr coincides with a new timeout, err SHALL remain 1.
REQ-018 A request arriving while dac_busy=1 in IDLE SHALL be held until dac_busy=0.

Reset
REQ-019 On reset=0 the block SHALL asynchronously set the following, with dac_trig dropping immediately (mid-frame included):
- FSM to IDLE; dac_trig=0, err=0, frame_cnt=0;
- shadow and frame buffer to DAC_MIDSCALE (16'h8000);
- dirty to 4'b1111; refresh counter to 0.
REQ-020 After reset release the block SHALL launch one mid-scale frame on the first cycle dac_busy=0.

Configuration
REQ-021 With DAC_REFRESH_EN defined:
- a counter SHALL increment every cycle and clear on each launch;
- refresh_due SHALL assert when the counter reaches REFRESH_CYCLES-1.
REQ-022 Without DAC_REFRESH_EN, no counter SHALL exist, refresh_due SHALL be 0, and frames launch only on dirty bits or safe edges.

Structure
REQ-023 The package dac_sched_pkg SHALL hold the FSM state type, DAC_MIDSCALE=16'h8000 and DAC_CMD_WRUPD=4'h3.
REQ-024 The refresh/timeout counting SHALL live in one sub-module, dac_sched_timer; everything else SHALL be flat.

Verification
REQ-025 Reset release with dac_busy=0 -> dac_trig pulses once; dac_word at dac_addr=0..3 reads 32'h0030_8000.
REQ-026 Write chan2=16'h1234 in IDLE -> dac_trig the next cycle; dac_word@2=32'h0030_1234; frame_cnt 0->1 after busy falls.
REQ-027 Write chan1=16'hAAAA during WAIT_DONE -> dac_word@1 unchanged until busy falls; second frame then carries 16'hAAAA.
REQ-028 safe 0->1 with shadow chan0=16'h1234 -> frame with all entries 16'h8000; safe 1->0 -> frame restores 16'h1234.
REQ-029 Hold dac_busy=0 after dac_trig -> err=1 at cycle 16 with frame_cnt unchanged; err_clr pulse -> err=0.
REQ-030 DAC_REFRESH_EN defined, REFRESH_CYCLES=100, no writes -> dac_trig every 100 cycles after the last launch; undefined -> no dac_trig.

Source files
------------

// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC update scheduler.
// Holds the FSM state encoding, mid-scale code and the write-and-update command word builder.
package dac_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRIG      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [15:0] DAC_MIDSCALE  = 16'h8000;
  localparam logic [3:0]  DAC_CMD_WRUPD = 4'h3;

  function automatic logic [31:0] dac_cmd_word(input logic [15:0] code);
    return {8'h00, DAC_CMD_WRUPD, 4'h0, code};
  endfunction

endpackage

// File: rtl/dac_sched_timer.sv
// Refresh interval and busy-timeout counters for the scheduler; outputs are combinational from registered counts.
// Refresh counter exists only with DAC_REFRESH_EN defined; otherwise o_refresh_due is tied low.
module dac_sched_timer #(
  parameter int REFRESH_CYCLES = 49152,
  parameter int BUSY_TIMEOUT   = 16
) (
  input  logic clkin,
  input  logic reset,
  input  logic i_launch,
  input  logic i_to_start,
  input  logic i_to_run,
  output logic o_refresh_due,
  output logic o_timeout
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

  // Count holds cycles elapsed since the trigger cycle while waiting for busy.
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (i_to_start) begin
      r_to_cnt <= TW'(1);
    end else if (i_to_run && (r_to_cnt < TO_LAST)) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign o_timeout = i_to_run && (r_to_cnt >= TO_LAST);

`ifdef DAC_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYCLES - 1);

  logic [RW-1:0] r_rf_cnt;

  // Saturates so a refresh that lands while the driver is busy stays requested.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      r_rf_cnt <= '0;
    end else if (i_launch) begin
      r_rf_cnt <= '0;
    end else if (r_rf_cnt < RF_LAST) begin
      r_rf_cnt <= r_rf_cnt + RW'(1);
    end
  end

  assign o_refresh_due = (r_rf_cnt >= RF_LAST);
`else
  logic w_unused_launch;
  assign w_unused_launch = i_launch;
  assign o_refresh_due   = 1'b0;
`endif

endmodule

// File: rtl/dac_update_sched.sv
// Shadows 4 DAC setpoints and launches one-cycle dac_trig frames 1 cycle after a launch decision; launches wait for dac_busy=0.
// Optional periodic refresh is enabled with DAC_REFRESH_EN.
module dac_update_sched
  import dac_sched_pkg::*;
#(
  parameter int REFRESH_CYCLES = 49152,
  parameter int BUSY_TIMEOUT   = 16
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_chan,
  input  logic [15:0] wr_data,
  input  logic        safe,
  input  logic        err_clr,
  input  logic [3:0]  dac_addr,
  input  logic        dac_busy,
  output logic        dac_trig,
  output logic [31:0] dac_word,
  output logic        pending,
  output logic [15:0] frame_cnt,
  output logic        err
);

  state_t           r_state;
  logic [3:0][15:0] r_shadow;
  logic [3:0][15:0] r_framebuf;
  logic [3:0]       r_dirty;
  logic             r_safe_d;
  logic             r_trig;
  logic             r_err;
  logic [15:0]      r_frame_cnt;

  logic             w_safe_edge;
  logic             w_launch;
  logic             w_refresh_due;
  logic             w_timeout;
  logic             w_to_fire;
  logic [3:0]       w_wr_mask;

  assign w_safe_edge = safe ^ r_safe_d;
  assign w_wr_mask   = wr_en ? (4'b0001 << wr_chan) : 4'b0000;
  assign w_launch    = (r_state == ST_IDLE) && !dac_busy &&
                       ((|r_dirty) || w_refresh_due || w_safe_edge);
  assign w_to_fire   = w_timeout && !dac_busy;

  dac_sched_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES),
    .BUSY_TIMEOUT  (BUSY_TIMEOUT)
  ) u_timer (
    .clkin        (clkin),
    .reset        (reset),
    .i_launch     (w_launch),
    .i_to_start   (r_state == ST_TRIG),
    .i_to_run     (r_state == ST_WAIT_BUSY),
    .o_refresh_due(w_refresh_due),
    .o_timeout    (w_timeout)
  );

  // A write in the launch cycle keeps its dirty bit so the new value goes out next frame.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      r_shadow   <= {4{DAC_MIDSCALE}};
      r_framebuf <= {4{DAC_MIDSCALE}};
      r_dirty    <= 4'b1111;
      r_safe_d   <= 1'b0;
    end else begin
      r_safe_d <= safe;
      if (wr_en) begin
        r_shadow[wr_chan] <= wr_data;
      end
      if (w_launch) begin
        r_framebuf <= safe ? {4{DAC_MIDSCALE}} : r_shadow;
        r_dirty    <= w_wr_mask;
      end else if (w_safe_edge) begin
        r_dirty <= 4'b1111;
      end else begin
        r_dirty <= r_dirty | w_wr_mask;
      end
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_trig      <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= 16'h0000;
    end else begin
      r_trig <= 1'b0;
      if (w_to_fire) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state <= ST_TRIG;
            r_trig  <= 1'b1;
          end
        end
        ST_TRIG: begin
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (dac_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (w_to_fire) begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          if (!dac_busy) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dac_trig  = r_trig;
  assign err       = r_err;
  assign frame_cnt = r_frame_cnt;
  assign pending   = |r_dirty;
  assign dac_word  = (dac_addr < 4'd4) ? dac_cmd_word(r_framebuf[dac_addr[1:0]]) : 32'h0;

endmodule

// File: tb/tb_dac_update_sched.sv
// Self-checking bench for dac_update_sched: write-vector table plus hand sequences, frames checked against a scoreboard.
// Refresh expectations follow DAC_REFRESH_EN.
module tb_dac_update_sched;

  logic        clkin    = 1'b0;
  logic        reset    = 1'b0;
  logic        wr_en    = 1'b0;
  logic [1:0]  wr_chan  = 2'd0;
  logic [15:0] wr_data  = 16'h0;
  logic        safe     = 1'b0;
  logic        err_clr  = 1'b0;
  logic [3:0]  dac_addr = 4'd0;
  logic        dac_busy = 1'b0;
  logic        dac_trig;
  logic [31:0] dac_word;
  logic        pending;
  logic [15:0] frame_cnt;
  logic        err;

  typedef logic [3:0][15:0] frame_t;
  typedef struct {
    logic [1:0]  chan;
    logic [15:0] data;
    logic [31:0] exp_word;
  } wr_vec_t;

  int      checks   = 0;
  int      failures = 0;
  int      cyc      = 0;
  int      exp_fc   = 0;
  frame_t  m_shadow;
  logic    m_safe;
  frame_t  sb_q[$];
  wr_vec_t vecs[4];

  always #10 clkin = ~clkin;

  dac_update_sched #(
    .REFRESH_CYCLES(100),
    .BUSY_TIMEOUT  (16)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_chan  (wr_chan),
    .wr_data  (wr_data),
    .safe     (safe),
    .err_clr  (err_clr),
    .dac_addr (dac_addr),
    .dac_busy (dac_busy),
    .dac_trig (dac_trig),
    .dac_word (dac_word),
    .pending  (pending),
    .frame_cnt(frame_cnt),
    .err      (err)
  );

  task automatic tick();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_frame();
    frame_t f;
    for (int i = 0; i < 4; i++) f[i] = m_safe ? 16'h8000 : m_shadow[i];
    sb_q.push_back(f);
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_chan = ch;
    wr_data = d;
    m_shadow[ch] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_trig(input string nm, input int maxn, input int exp_n);
    int n = 0;
    while (!dac_trig && n < maxn) begin
      tick();
      n++;
    end
    chk({nm, "_trig"}, {31'd0, dac_trig}, 32'd1);
    if (exp_n >= 0) chk({nm, "_latency"}, n, exp_n);
  endtask

  task automatic start_busy();
    tick();
    chk("trig_one_cycle", {31'd0, dac_trig}, 32'd0);
    dac_busy = 1'b1;
    tick();
  endtask

  task automatic check_frame(input string nm);
    frame_t e;
    logic [3:0] hi_addr;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb_empty: got no expected frame, required one", nm);
    end else begin
      e = sb_q.pop_front();
      for (int a = 0; a < 4; a++) begin
        dac_addr = a[3:0];
        #1;
        chk({nm, "_word"}, dac_word, {8'h00, 4'h3, 4'h0, e[a]});
      end
      hi_addr = 4'd4 + 4'($urandom_range(0, 11));
      dac_addr = hi_addr;
      #1;
      chk({nm, "_word_hi"}, dac_word, 32'h0);
    end
    dac_addr = 4'd0;
  endtask

  task automatic end_busy();
    dac_busy = 1'b0;
    tick();
    exp_fc++;
    chk("frame_cnt", {16'd0, frame_cnt}, exp_fc);
  endtask

  task automatic serve(input string nm);
    start_busy();
    check_frame(nm);
    end_busy();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int k;
    int t1;
    vecs[0] = '{2'd2, 16'h1234, 32'h0030_1234};
    vecs[1] = '{2'd0, 16'hFFFF, 32'h0030_FFFF};
    vecs[2] = '{2'd3, 16'h0000, 32'h0030_0000};
    vecs[3] = '{2'd1, 16'h5A5A, 32'h0030_5A5A};
    m_shadow = {4{16'h8000}};
    m_safe   = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_trig", {31'd0, dac_trig}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_pending", {31'd0, pending}, 32'd1);
    for (int a = 0; a < 4; a++) begin
      dac_addr = a[3:0];
      #1;
      chk("rst_word", dac_word, 32'h0030_8000);
    end
    dac_addr = 4'd0;

    push_frame();
    reset = 1'b1;
    wait_trig("release", 5, 1);
    serve("release");
    chk("idle_pending", {31'd0, pending}, 32'd0);

    // Table of single-channel writes
    for (int v = 0; v < 4; v++) begin
      do_write(vecs[v].chan, vecs[v].data);
      chk("wr_pending", {31'd0, pending}, 32'd1);
      push_frame();
      wait_trig("wr", 4, 1);
      start_busy();
      check_frame("wr");
      dac_addr = {2'b00, vecs[v].chan};
      #1;
      chk("wr_vec_word", dac_word, vecs[v].exp_word);
      dac_addr = 4'd0;
      end_busy();
    end

    // Writes during WAIT_DONE must not tear the frame; last of two writes wins
    do_write(2'd2, 16'h1111);
    push_frame();
    wait_trig("mid_a", 4, 1);
    start_busy();
    do_write(2'd1, 16'h1357);
    do_write(2'd1, 16'hAAAA);
    chk("mid_pending", {31'd0, pending}, 32'd1);
    check_frame("mid_hold");
    push_frame();
    end_busy();
    wait_trig("mid_b", 4, 1);
    serve("mid_b");
    chk("mid_done_pending", {31'd0, pending}, 32'd0);

    // Write coinciding with the launch cycle goes out in the following frame
    wr_en = 1'b1; wr_chan = 2'd0; wr_data = 16'h0F0F; m_shadow[0] = 16'h0F0F;
    tick();
    push_frame();
    wr_data = 16'hF0F0; m_shadow[0] = 16'hF0F0;
    tick();
    wr_en = 1'b0;
    wait_trig("coin_a", 4, 0);
    push_frame();
    serve("coin_a");
    wait_trig("coin_b", 4, 1);
    serve("coin_b");

    // Request held while driver busy in IDLE
    dac_busy = 1'b1;
    do_write(2'd3, 16'h4242);
    seen = 0;
    repeat (6) begin
      tick();
      if (dac_trig) seen++;
    end
    chk("busy_hold", seen, 0);
    push_frame();
    dac_busy = 1'b0;
    wait_trig("busy_release", 4, 1);
    serve("busy_release");

    // Safe edges
    do_write(2'd0, 16'h1234);
    push_frame();
    wait_trig("safe_pre", 4, 1);
    serve("safe_pre");
    safe = 1'b1; m_safe = 1'b1;
    push_frame();
    wait_trig("safe_rise", 4, 1);
    serve("safe_rise");
    do_write(2'd3, 16'h7777);
    push_frame();
    wait_trig("safe_wr", 4, 1);
    serve("safe_wr");
    safe = 1'b0; m_safe = 1'b0;
    push_frame();
    wait_trig("safe_fall", 4, 1);
    serve("safe_fall");

    // Busy timeout
    do_write(2'd1, 16'h2222);
    push_frame();
    wait_trig("to", 4, 1);
    check_frame("to");
    k = 0;
    while (!err && k < 24) begin
      tick();
      k++;
    end
    chk("to_cycles", k, 16);
    chk("to_fcnt", {16'd0, frame_cnt}, exp_fc);
    repeat (3) tick();
    chk("to_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clear", {31'd0, err}, 32'd0);

    // Timeout wins over a coincident err_clr
    err_clr = 1'b1;
    do_write(2'd2, 16'h3333);
    push_frame();
    wait_trig("to2", 4, 1);
    check_frame("to2");
    k = 0;
    while (!err && k < 24) begin
      tick();
      k++;
    end
    err_clr = 1'b0;
    chk("to2_cycles", k, 16);
    tick();
    chk("to2_held", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to2_clear", {31'd0, err}, 32'd0);

    // Periodic refresh
`ifdef DAC_REFRESH_EN
    wait_trig("refresh1", 150, -1);
    t1 = cyc;
    start_busy();
    end_busy();
    wait_trig("refresh2", 150, -1);
    chk("refresh_period", cyc - t1, 100);
    start_busy();
    end_busy();
`else
    t1 = 0;
    seen = 0;
    repeat (250) begin
      tick();
      if (dac_trig) seen++;
    end
    chk("no_refresh", seen, t1);
`endif

    // Asynchronous reset in the middle of a frame
    do_write(2'd0, 16'h5555);
    wait_trig("arst", 4, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_trig", {31'd0, dac_trig}, 32'd0);
    chk("arst_fcnt", {16'd0, frame_cnt}, 32'd0);
    chk("arst_pending", {31'd0, pending}, 32'd1);
    dac_addr = 4'd0;
    #1;
    chk("arst_word", dac_word, 32'h0030_8000);
    exp_fc   = 0;
    m_shadow = {4{16'h8000}};
    sb_q.delete();
    push_frame();
    tick();
    reset = 1'b1;
    wait_trig("arst_release", 4, 1);
    serve("arst_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
